// File: rtl/tt_mux_ctrl.sv
// rtl/tt_mux_ctrl.sv - project-select controller for the muxed tile array
//
// Purpose: selects one of N_PROJ project wrappers from three slow pad pins
// (reset-address, increment-address, enable), holds the newly selected
// project in reset for SETTLE_CYC clocks, broadcasts the pad inputs on iw and
// returns the selected wrapper's outputs to the pads, registered.
//
// Ports:
//   clk, rst                    system clock, asynchronous active-high reset
//   ctrl_sel_rst/inc/ena        asynchronous control pins (synchronised here)
//   pad_proj_clk/rst_n          project clock and reset_n from pads
//   pad_ui_in, pad_uio_in       project inputs from pads
//   iw                          {uio_in, ui_in, rst_n, clk} to every wrapper
//   ena                         one-hot project enable, zero when idle
//   ow_all                      wrapper p at [24p+23:24p] = {uio_oe, uio_out, uo_out}
//   pad_uo_out/uio_out/uio_oe   registered outputs of the selected project
//   sel_addr, active            current address, ACTIVE-state flag
module tt_mux_ctrl #(
    parameter int N_PROJ     = 4,
    parameter int ADDR_W     = 2,
    parameter int SETTLE_CYC = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ctrl_sel_rst,
    input  logic                 ctrl_sel_inc,
    input  logic                 ctrl_ena,
    input  logic                 pad_proj_clk,
    input  logic                 pad_proj_rst_n,
    input  logic [7:0]           pad_ui_in,
    input  logic [7:0]           pad_uio_in,
    output logic [17:0]          iw,
    output logic [N_PROJ-1:0]    ena,
    input  logic [24*N_PROJ-1:0] ow_all,
    output logic [7:0]           pad_uo_out,
    output logic [7:0]           pad_uio_out,
    output logic [7:0]           pad_uio_oe,
    output logic [ADDR_W-1:0]    sel_addr,
    output logic                 active
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_ACTIVE} state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [N_PROJ-1:0]   ena_q, ena_d;
    logic [23:0]         pad_q, pad_d;
    logic [1:0]          sel_rst_sync_q, sel_rst_sync_d;
    logic [2:0]          inc_sync_q, inc_sync_d;
    logic [1:0]          ena_sync_q, ena_sync_d;

    logic                sel_rst_s, inc_edge, ena_s, addr_chg, running;
    logic [23:0]         ow_sel;

    function automatic logic [N_PROJ-1:0] onehot(input logic [ADDR_W-1:0] a);
        logic [N_PROJ-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    // Two-stage synchronisers; inc keeps a third stage for edge detection.
    always_comb begin
        sel_rst_sync_d = {sel_rst_sync_q[0], ctrl_sel_rst};
        inc_sync_d     = {inc_sync_q[1:0], ctrl_sel_inc};
        ena_sync_d     = {ena_sync_q[0], ctrl_ena};
    end

    assign sel_rst_s = sel_rst_sync_q[1];
    assign inc_edge  = inc_sync_q[1] & ~inc_sync_q[2];
    assign ena_s     = ena_sync_q[1];

    // Address: clear wins over an increment seen in the same cycle.
    always_comb begin
        addr_d = addr_q;
        if (sel_rst_s) begin
            addr_d = '0;
        end else if (inc_edge) begin
            addr_d = (addr_q == ADDR_W'(N_PROJ - 1)) ? '0 : addr_q + ADDR_W'(1);
        end
    end

    assign addr_chg = (addr_d != addr_q);

    // ena is computed from the next address, so on a switch the old bit
    // falls and the new bit rises on the same edge from one register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ena_d   = ena_q;
        case (state_q)
            ST_IDLE: begin
                ena_d = '0;
                if (ena_s && !sel_rst_s) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                    ena_d   = onehot(addr_d);
                end
            end
            default: begin
                if (!ena_s || sel_rst_s) begin
                    state_d = ST_IDLE;
                    ena_d   = '0;
                end else if (addr_chg) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                    ena_d   = onehot(addr_d);
                end else if (state_q == ST_SETTLE) begin
                    if (cnt_q == '0) begin
                        state_d = ST_ACTIVE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        ow_sel = '0;
        for (int p = 0; p < N_PROJ; p++) begin
            if (addr_q == ADDR_W'(p)) begin
                ow_sel = ow_all[24*p +: 24];
            end
        end
    end

    // Return register loads zero outside ACTIVE so uio_oe tri-states the pads.
    always_comb begin
        pad_d = (state_q == ST_ACTIVE) ? ow_sel : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            addr_q         <= '0;
            ena_q          <= '0;
            pad_q          <= '0;
            sel_rst_sync_q <= '0;
            inc_sync_q     <= '0;
            ena_sync_q     <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            addr_q         <= addr_d;
            ena_q          <= ena_d;
            pad_q          <= pad_d;
            sel_rst_sync_q <= sel_rst_sync_d;
            inc_sync_q     <= inc_sync_d;
            ena_sync_q     <= ena_sync_d;
        end
    end

    assign running = (state_q != ST_IDLE);

    assign iw = {running ? pad_uio_in : 8'h00,
                 running ? pad_ui_in  : 8'h00,
                 (state_q == ST_ACTIVE) & pad_proj_rst_n,
                 pad_proj_clk & running};

    assign ena         = ena_q;
    assign sel_addr    = addr_q;
    assign active      = (state_q == ST_ACTIVE);
    assign pad_uo_out  = pad_q[7:0];
    assign pad_uio_out = pad_q[15:8];
    assign pad_uio_oe  = pad_q[23:16];

endmodule

// File: tb/tb_tt_mux_ctrl.sv
// tb/tb_tt_mux_ctrl.sv - directed self-checking bench for tt_mux_ctrl
module tb_tt_mux_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ctrl_sel_rst, ctrl_sel_inc, ctrl_ena;
    logic        pad_proj_clk, pad_proj_rst_n;
    logic [7:0]  pad_ui_in, pad_uio_in;
    logic [17:0] iw;
    logic [3:0]  ena;
    logic [95:0] ow_all;
    logic [7:0]  pad_uo_out, pad_uio_out, pad_uio_oe;
    logic [1:0]  sel_addr;
    logic        active;

    int total = 0;
    int bad   = 0;

    tt_mux_ctrl #(.N_PROJ(4), .ADDR_W(2), .SETTLE_CYC(8)) dut (
        .clk(clk), .rst(rst),
        .ctrl_sel_rst(ctrl_sel_rst), .ctrl_sel_inc(ctrl_sel_inc), .ctrl_ena(ctrl_ena),
        .pad_proj_clk(pad_proj_clk), .pad_proj_rst_n(pad_proj_rst_n),
        .pad_ui_in(pad_ui_in), .pad_uio_in(pad_uio_in),
        .iw(iw), .ena(ena), .ow_all(ow_all),
        .pad_uo_out(pad_uo_out), .pad_uio_out(pad_uio_out), .pad_uio_oe(pad_uio_oe),
        .sel_addr(sel_addr), .active(active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  ui;
        logic [7:0]  uio;
        logic        prst_n;
        logic        pclk;
        logic [95:0] ow;
        logic [17:0] exp_iw;
        logic [23:0] exp_pad;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock, sampled on the falling edge; ena must never be multi-hot.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        chk("ena_onehot0", 32'($countones(ena) <= 1), 32'd1);
    endtask

    task automatic pulse_inc(input logic [1:0] old_a, input logic [1:0] new_a);
        ctrl_sel_inc = 1'b1;
        tick();
        ctrl_sel_inc = 1'b0;
        tick();
        chk("inc_latency", 32'(sel_addr), 32'(old_a));
        tick();
        chk("inc_addr", 32'(sel_addr), 32'(new_a));
        chk("inc_ena", 32'(ena), 32'd1 << new_a);
        chk("inc_settle", 32'(active), 32'd0);
        tick();
        tick();
    endtask

    task automatic wait_active(input string name);
        for (int i = 0; i < 20 && !active; i++) tick();
        chk(name, 32'(active), 32'd1);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 8'h3C, 1'b1, 1'b1,
                    {24'hCCCCCC, 24'h123456, 24'hBBBBBB, 24'hAAAAAA},
                    {8'h3C, 8'hA5, 1'b1, 1'b1}, 24'h123456};
        vecs[1] = '{8'h00, 8'hFF, 1'b0, 1'b0,
                    {24'h111111, 24'hFEDCBA, 24'h222222, 24'h333333},
                    {8'hFF, 8'h00, 1'b0, 1'b0}, 24'hFEDCBA};
        vecs[2] = '{8'h81, 8'h18, 1'b1, 1'b0,
                    {24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'hFFFFFF},
                    {8'h18, 8'h81, 1'b1, 1'b0}, 24'h000000};
        vecs[3] = '{8'h5A, 8'h00, 1'b0, 1'b1,
                    {24'h000000, 24'hA1B2C3, 24'h000000, 24'h000000},
                    {8'h00, 8'h5A, 1'b0, 1'b1}, 24'hA1B2C3};

        rst = 1'b1;
        ctrl_sel_rst = 1'b0; ctrl_sel_inc = 1'b0; ctrl_ena = 1'b0;
        pad_proj_clk = 1'b1; pad_proj_rst_n = 1'b1;
        pad_ui_in = 8'hA5; pad_uio_in = 8'h00;
        ow_all = '1;
        repeat (3) @(negedge clk);
        chk("rst_ena", 32'(ena), 32'd0);
        chk("rst_addr", 32'(sel_addr), 32'd0);
        chk("rst_pads", 32'({pad_uio_oe, pad_uio_out, pad_uo_out}), 32'd0);
        chk("rst_iw", 32'(iw), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_pads", 32'({pad_uio_oe, pad_uio_out, pad_uo_out}), 32'd0);

        // Enable: ena appears on the third clock, rst_n held low for 8 clocks.
        ctrl_ena = 1'b1;
        tick();
        tick();
        chk("ena_c2", 32'(ena), 32'd0);
        tick();
        chk("ena_c3", 32'(ena), 32'h1);
        chk("settle_rstn_c3", 32'(iw[1]), 32'd0);
        chk("settle_clk_c3", 32'(iw[0]), 32'd1);
        for (int c = 4; c <= 10; c++) begin
            tick();
            chk("settle_rstn", 32'(iw[1]), 32'd0);
            chk("settle_active", 32'(active), 32'd0);
        end
        tick();
        chk("active_c11", 32'(active), 32'd1);
        chk("active_iw", 32'(iw), 32'({8'h00, 8'hA5, 1'b1, 1'b1}));

        pulse_inc(2'd0, 2'd1);
        pulse_inc(2'd1, 2'd2);
        pulse_inc(2'd2, 2'd3);
        pulse_inc(2'd3, 2'd0);
        pulse_inc(2'd0, 2'd1);
        pulse_inc(2'd1, 2'd2);
        wait_active("wait_active_a2");

        foreach (vecs[i]) begin
            pad_ui_in      = vecs[i].ui;
            pad_uio_in     = vecs[i].uio;
            pad_proj_rst_n = vecs[i].prst_n;
            pad_proj_clk   = vecs[i].pclk;
            ow_all         = vecs[i].ow;
            #1;
            chk($sformatf("vec%0d_iw", i), 32'(iw), 32'(vecs[i].exp_iw));
            tick();
            chk($sformatf("vec%0d_pad", i),
                32'({pad_uio_oe, pad_uio_out, pad_uo_out}), 32'(vecs[i].exp_pad));
        end

        ctrl_ena = 1'b0;
        tick();
        tick();
        chk("drop_latency", 32'(active), 32'd1);
        tick();
        chk("drop_ena", 32'(ena), 32'd0);
        chk("drop_active", 32'(active), 32'd0);
        tick();
        chk("drop_pads", 32'({pad_uio_oe, pad_uio_out, pad_uo_out}), 32'd0);
        chk("drop_iw", 32'(iw), 32'd0);

        // Clear and increment arriving together: clear wins.
        ctrl_ena = 1'b1;
        wait_active("wait_active_b");
        chk("pre_clr_addr", 32'(sel_addr), 32'd2);
        ctrl_sel_rst = 1'b1;
        ctrl_sel_inc = 1'b1;
        tick();
        ctrl_sel_inc = 1'b0;
        tick();
        chk("clr_latency", 32'(active), 32'd1);
        tick();
        chk("clr_addr", 32'(sel_addr), 32'd0);
        chk("clr_active", 32'(active), 32'd0);
        chk("clr_ena", 32'(ena), 32'd0);
        tick();
        tick();
        chk("clr_hold_idle", 32'(ena), 32'd0);
        ctrl_sel_rst = 1'b0;
        tick();
        tick();
        tick();
        chk("clr_release_ena", 32'(ena), 32'h1);

        // Asynchronous reset mid-ACTIVE clears outputs before the next edge.
        ow_all = {72'd0, 24'h0F0F0F};
        wait_active("wait_active_c");
        tick();
        chk("pre_rst_pad", 32'({pad_uio_oe, pad_uio_out, pad_uo_out}), 32'h0F0F0F);
        #2;
        rst = 1'b1;
        #1;
        chk("async_ena", 32'(ena), 32'd0);
        chk("async_pads", 32'({pad_uio_oe, pad_uio_out, pad_uo_out}), 32'd0);
        chk("async_active", 32'(active), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
